// File: rtl/issue_pkg.sv
// Shared issue-queue types: default queue depth and the entry index, occupancy count and age-matrix types.
package issue_pkg;
  localparam int DEF_N_ENTRIES = 8;
  localparam int DEF_IDX_W     = $clog2(DEF_N_ENTRIES);
  localparam int DEF_CNT_W     = $clog2(DEF_N_ENTRIES + 1);

  typedef logic [DEF_IDX_W-1:0]                    entry_idx_t;
  typedef logic [DEF_CNT_W-1:0]                    entry_cnt_t;
  typedef logic [DEF_N_ENTRIES-1:0][DEF_N_ENTRIES-1:0] age_matrix_t;
endpackage

// File: rtl/age_matrix_ram.sv
// N x N older-than storage with one row-write port and one column-write port applied together.
// The column write wins on the shared diagonal bit; rows_o/cols_o are the row-major and transposed reads.
module age_matrix_ram
  import issue_pkg::*;
#(
  parameter  int N_ENTRIES = DEF_N_ENTRIES,
  localparam int IDX_W     = $clog2(N_ENTRIES)
) (
  input  logic                                clk,
  input  logic                                rst_aL,
  input  logic                                row_we_i,
  input  logic [IDX_W-1:0]                    row_idx_i,
  input  logic [N_ENTRIES-1:0]                row_data_i,
  input  logic                                col_we_i,
  input  logic [IDX_W-1:0]                    col_idx_i,
  input  logic [N_ENTRIES-1:0]                col_data_i,
  output logic [N_ENTRIES-1:0][N_ENTRIES-1:0] rows_o,
  output logic [N_ENTRIES-1:0][N_ENTRIES-1:0] cols_o
);
  logic [N_ENTRIES-1:0][N_ENTRIES-1:0] mat_q;

  // NOTE: this storage is flops, not a RAM macro, so it takes the async reset;
  // an asserted reset must clear it without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      mat_q <= '0;
    end else begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        for (int j = 0; j < N_ENTRIES; j++) begin
          // NOTE: non-blocking assignments keep every bit reading pre-edge state.
          if (col_we_i && IDX_W'(j) == col_idx_i) begin
            mat_q[i][j] <= col_data_i[i];
          end else if (row_we_i && IDX_W'(i) == row_idx_i) begin
            mat_q[i][j] <= row_data_i[j];
          end
        end
      end
    end
  end

  assign rows_o = mat_q;

  always_comb begin
    // NOTE: default first so no path through this block infers a latch.
    cols_o = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      for (int j = 0; j < N_ENTRIES; j++) begin
        cols_o[j][i] = mat_q[i][j];
      end
    end
  end
endmodule

// File: rtl/age_matrix_select.sv
// Oldest-ready selector for an issue queue built on an older-than age matrix.
// Define AGE_MATRIX_SELECT_CHECK_EN to add the dbg_matrix port and simulation assertions.
module age_matrix_select
  import issue_pkg::*;
#(
  parameter  int N_ENTRIES = DEF_N_ENTRIES,
  localparam int IDX_W     = $clog2(N_ENTRIES),
  localparam int CNT_W     = $clog2(N_ENTRIES + 1)
) (
  input  logic                 clk,
  input  logic                 rst_aL,
  input  logic                 alloc_en,
  input  logic [IDX_W-1:0]     alloc_idx,
  input  logic [N_ENTRIES-1:0] req,
  input  logic                 issue_ready,
  input  logic                 flush,
  output logic                 gnt_valid,
  output logic [IDX_W-1:0]     gnt_idx,
  output logic [N_ENTRIES-1:0] gnt_onehot,
  output logic [N_ENTRIES-1:0] valid,
  output logic [CNT_W-1:0]     count,
  output logic                 full,
  output logic                 empty
`ifdef AGE_MATRIX_SELECT_CHECK_EN
  ,
  output logic [N_ENTRIES-1:0][N_ENTRIES-1:0] dbg_matrix
`endif
);
  logic [N_ENTRIES-1:0]                valid_q, valid_d;
  logic [N_ENTRIES-1:0]                req_eff, alloc_oh;
  logic [N_ENTRIES-1:0][N_ENTRIES-1:0] rows, cols;
  logic                                issue_fire, alloc_fire;

  assign req_eff    = req & valid_q;
  assign issue_fire = gnt_valid & issue_ready;
  assign alloc_fire = alloc_en & ~full & ~flush;

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    alloc_oh   = '0;
    count      = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      // cols[i] lists the entries older than i; any requesting one blocks i.
      if (req_eff[i] && !(|(req_eff & cols[i]))) gnt_onehot[i] = 1'b1;
      if (gnt_onehot[i]) gnt_idx = IDX_W'(i);
      if (IDX_W'(i) == alloc_idx) alloc_oh[i] = 1'b1;
      count = count + CNT_W'(valid_q[i]);
    end
  end

  assign gnt_valid = |req_eff;
  assign valid     = valid_q;
  assign full      = (count == CNT_W'(N_ENTRIES));
  assign empty     = (count == '0);

  always_comb begin
    valid_d = valid_q;
    if (flush) begin
      valid_d = '0;
    end else begin
      if (issue_fire) valid_d = valid_d & ~gnt_onehot;
      if (alloc_fire) valid_d = valid_d | alloc_oh;
    end
  end

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) valid_q <= '0;
    else         valid_q <= valid_d;
  end

  // New entry: older than nobody (row cleared), younger than every valid entry (column).
  age_matrix_ram #(.N_ENTRIES(N_ENTRIES)) u_ram (
    .clk        (clk),
    .rst_aL     (rst_aL),
    .row_we_i   (alloc_fire),
    .row_idx_i  (alloc_idx),
    .row_data_i ('0),
    .col_we_i   (alloc_fire),
    .col_idx_i  (alloc_idx),
    .col_data_i (valid_q & ~alloc_oh),
    .rows_o     (rows),
    .cols_o     (cols)
  );

`ifdef AGE_MATRIX_SELECT_CHECK_EN
  assign dbg_matrix = rows;

  always @(posedge clk) begin
    if (rst_aL) begin
      assert (!(alloc_en && |(valid_q & alloc_oh))) else $error("alloc to a valid entry");
      assert (!(alloc_en && full)) else $error("alloc while full");
      assert ($onehot0(gnt_onehot)) else $error("grant not onehot0");
      for (int i = 0; i < N_ENTRIES; i++) begin
        for (int j = 0; j < N_ENTRIES; j++) begin
          assert (!(valid_q[i] && valid_q[j] && rows[i][j] && rows[j][i]))
            else $error("age matrix not antisymmetric at %0d,%0d", i, j);
        end
      end
    end
  end
`else
  logic unused_rows;
  assign unused_rows = ^rows;
`endif
endmodule

// File: tb/tb_age_matrix_select.sv
// Directed table-driven bench for age_matrix_select at N_ENTRIES=4, plus reset and async-reset sequences.
module tb_age_matrix_select;
  logic       clk = 1'b0;
  logic       rst_aL;
  logic       alloc_en;
  logic [1:0] alloc_idx;
  logic [3:0] req;
  logic       issue_ready;
  logic       flush;
  logic       gnt_valid;
  logic [1:0] gnt_idx;
  logic [3:0] gnt_onehot;
  logic [3:0] valid;
  logic [2:0] count;
  logic       full;
  logic       empty;

  int total = 0;
  int bad   = 0;

  age_matrix_select #(.N_ENTRIES(4)) dut (
    .clk         (clk),
    .rst_aL      (rst_aL),
    .alloc_en    (alloc_en),
    .alloc_idx   (alloc_idx),
    .req         (req),
    .issue_ready (issue_ready),
    .flush       (flush),
    .gnt_valid   (gnt_valid),
    .gnt_idx     (gnt_idx),
    .gnt_onehot  (gnt_onehot),
    .valid       (valid),
    .count       (count),
    .full        (full),
    .empty       (empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       a_en;
    logic [1:0] a_idx;
    logic [3:0] req;
    logic       rdy;
    logic       fl;
    logic       gv;
    logic [1:0] gi;
    logic [3:0] goh;
    logic [3:0] vld;
    logic [2:0] cnt;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state(input string tag, input logic gv, input logic [1:0] gi,
                             input logic [3:0] goh, input logic [3:0] vld, input logic [2:0] cnt);
    check({tag, ".gnt_valid"},  32'(gnt_valid),  32'(gv));
    check({tag, ".gnt_idx"},    32'(gnt_idx),    32'(gi));
    check({tag, ".gnt_onehot"}, 32'(gnt_onehot), 32'(goh));
    check({tag, ".valid"},      32'(valid),      32'(vld));
    check({tag, ".count"},      32'(count),      32'(cnt));
    check({tag, ".full"},       32'(full),       32'(cnt == 3'd4));
    check({tag, ".empty"},      32'(empty),      32'(cnt == 3'd0));
  endtask

  initial begin
    // a_en idx  req     rdy  fl    gv  gi  goh      valid    cnt
    vecs[0]  = '{1, 2, 4'b1111, 0, 0,  0, 0, 4'b0000, 4'b0000, 0};
    vecs[1]  = '{1, 0, 4'b1111, 0, 0,  1, 2, 4'b0100, 4'b0100, 1};
    vecs[2]  = '{1, 3, 4'b1111, 0, 0,  1, 2, 4'b0100, 4'b0101, 2};
    vecs[3]  = '{0, 0, 4'b1001, 0, 0,  1, 0, 4'b0001, 4'b1101, 3};
    vecs[4]  = '{1, 1, 4'b1111, 1, 0,  1, 2, 4'b0100, 4'b1101, 3};
    vecs[5]  = '{0, 0, 4'b1111, 1, 0,  1, 0, 4'b0001, 4'b1011, 3};
    vecs[6]  = '{0, 0, 4'b1111, 1, 0,  1, 3, 4'b1000, 4'b1010, 2};
    vecs[7]  = '{0, 0, 4'b1111, 1, 0,  1, 1, 4'b0010, 4'b0010, 1};
    vecs[8]  = '{0, 0, 4'b1111, 0, 0,  0, 0, 4'b0000, 4'b0000, 0};
    vecs[9]  = '{1, 2, 4'b0000, 0, 0,  0, 0, 4'b0000, 4'b0000, 0};
    vecs[10] = '{1, 0, 4'b0000, 0, 0,  0, 0, 4'b0000, 4'b0100, 1};
    vecs[11] = '{1, 3, 4'b0100, 1, 0,  1, 2, 4'b0100, 4'b0101, 2};
    vecs[12] = '{1, 2, 4'b0000, 0, 0,  0, 0, 4'b0000, 4'b1001, 2};
    vecs[13] = '{1, 1, 4'b0000, 0, 0,  0, 0, 4'b0000, 4'b1101, 3};
    vecs[14] = '{1, 0, 4'b0000, 0, 0,  0, 0, 4'b0000, 4'b1111, 4};
    vecs[15] = '{0, 0, 4'b1111, 1, 0,  1, 0, 4'b0001, 4'b1111, 4};
    vecs[16] = '{0, 0, 4'b1111, 1, 0,  1, 3, 4'b1000, 4'b1110, 3};
    vecs[17] = '{0, 0, 4'b1111, 1, 0,  1, 2, 4'b0100, 4'b0110, 2};
    vecs[18] = '{0, 0, 4'b1111, 1, 0,  1, 1, 4'b0010, 4'b0010, 1};
    vecs[19] = '{0, 0, 4'b1111, 0, 0,  0, 0, 4'b0000, 4'b0000, 0};
    vecs[20] = '{1, 0, 4'b0000, 0, 0,  0, 0, 4'b0000, 4'b0000, 0};
    vecs[21] = '{1, 2, 4'b0000, 0, 0,  0, 0, 4'b0000, 4'b0001, 1};
    vecs[22] = '{1, 1, 4'b1111, 1, 1,  1, 0, 4'b0001, 4'b0101, 2};
    vecs[23] = '{0, 0, 4'b1111, 0, 0,  0, 0, 4'b0000, 4'b0000, 0};

    // Reset held with live requests and an in-flight alloc.
    rst_aL = 1'b0; alloc_en = 1'b1; alloc_idx = 2'd0;
    req = 4'b1111; issue_ready = 1'b1; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_state("reset", 0, 0, 4'b0000, 4'b0000, 0);
    rst_aL = 1'b1; alloc_en = 1'b0; issue_ready = 1'b0; req = 4'b0000;

    for (int v = 0; v < NV; v++) begin
      alloc_en = vecs[v].a_en; alloc_idx = vecs[v].a_idx; req = vecs[v].req;
      issue_ready = vecs[v].rdy; flush = vecs[v].fl;
      @(negedge clk);
      check_state($sformatf("vec%0d", v), vecs[v].gv, vecs[v].gi, vecs[v].goh,
                  vecs[v].vld, vecs[v].cnt);
      @(posedge clk);
      #1;
    end

    // Async reset mid-burst: must clear outputs without any clock edge.
    alloc_en = 1'b1; alloc_idx = 2'd1; req = 4'b1111; issue_ready = 1'b0; flush = 1'b0;
    @(posedge clk); #1;
    alloc_idx = 2'd3;
    @(posedge clk); #1;
    check("burst.valid", 32'(valid), 32'(4'b1010));
    alloc_idx = 2'd0; issue_ready = 1'b1;
    #2 rst_aL = 1'b0;
    #1;
    check_state("async_rst", 0, 0, 4'b0000, 4'b0000, 0);
    @(posedge clk); #1;
    rst_aL = 1'b1; alloc_en = 1'b1; alloc_idx = 2'd2; issue_ready = 1'b0;
    @(posedge clk); #1;
    alloc_en = 1'b0;
    @(negedge clk);
    check_state("post_rst", 1, 2, 4'b0100, 4'b0100, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/age_matrix_select.md
# age_matrix_select

Age-ordered oldest-ready selector for an issue queue. It keeps an N×N "older-than" matrix plus per-entry valid bits. It updates one row and one column on every allocation and picks the oldest ready valid entry each cycle. The issue queue sits between dispatch and the functional units: it drives allocations and ready masks in, and takes the grant back out as its issue pick.

## Interface
- N_ENTRIES, 8: number of queue entries, ≥2
- IDX_W, $clog2(N_ENTRIES): localparam, entry index width
- CNT_W, $clog2(N_ENTRIES+1): localparam, occupancy count width
- clk  in  1  sole clock, rising edge
- rst_aL  in  1  asynchronous, active-low reset
- alloc_en  in  1  allocate entry alloc_idx as youngest
- alloc_idx  in  IDX_W  entry being allocated; must be invalid, or issuing this cycle is illegal
- req  in  N_ENTRIES  per-entry ready mask from issue queue
- issue_ready  in  1  consumer accepts current grant
- flush  in  1  synchronous invalidate of all entries
- gnt_valid  out  1  some valid entry is requesting
- gnt_idx  out  IDX_W  index of oldest requesting entry
- gnt_onehot  out  N_ENTRIES  one-hot form of gnt_idx; all zero when !gnt_valid
- valid  out  N_ENTRIES  registered valid bits
- count  out  CNT_W  popcount of valid
- full / empty  out  1  count==N_ENTRIES / count==0

## Operation
- State: older[i][j]=1 means entry i is older than entry j. The matrix resets to all-zero and valid resets to 0.
- Effective request: req_eff = req & valid. Invalid entries are never granted, and their stale matrix bits are masked.
- Select: entry i wins iff req_eff[i] and no j has req_eff[j] & older[j][i]. Exactly one winner whenever req_eff≠0.
- issue_fire = gnt_valid & issue_ready. The granted entry's valid bit clears. Matrix bits are not touched on dealloc.
- Allocation of k: row k ← 0; column k ← valid with bit k forced 0. The new entry is younger than every currently valid entry; valid[k] ← 1.
- Same-cycle alloc and issue_fire on different entries: both apply. Column k uses pre-update valid, which is harmless because the issued entry becomes invalid.
- Alloc to an already valid entry: re-ages it as youngest. This is flagged by the checker (see Configuration).
- Alloc while full: ignored, state unchanged.
- flush: valid ← 0 and overrides alloc and issue in the same cycle. The matrix is left as is.
- Entry reuse (wrap-around) needs no cleanup, since allocation rewrites both the row and the column of the entry.

## Timing
- Grant is combinational from registered state plus req; it is valid in the same cycle as req.
- Allocation at edge t makes the entry grantable from cycle t+1 (zero bypass).
- Issue at edge t makes the entry disappear from valid and count in cycle t+1.
- count, full and empty are derived from registered valid.
- Reset, including asynchronous assertion mid-operation:
  - valid=0, count=0, empty=1, full=0.
  - gnt_valid=0, gnt_onehot=0, gnt_idx=0.
  - Matrix cleared immediately; in-flight allocs and issues are discarded.

## Configuration
- AGE_MATRIX_SELECT_CHECK_EN defined:
  - Adds output dbg_matrix [N_ENTRIES-1:0][N_ENTRIES-1:0] mirroring older.
  - Enables simulation assertions: no alloc to a valid entry, no alloc when full, gnt_onehot is onehot0, and antisymmetry (older[i][j] & older[j][i] never both set for valid i,j).
- Undefined: no dbg_matrix port, no assertions, and identical functional behaviour.

## Structure
- Shared package issue_pkg holds:
  - N_ENTRIES default
  - typedef of the entry index
  - typedef of the count
  - typedef of the age matrix (packed 2-D)
- Sub-module age_matrix_ram holds:
  - Matrix storage with one row-write port and one column-write port, both applied in the same cycle. The column write takes precedence on the diagonal bit.
  - Row and column read ports.
  - Async active-low reset.

## Test plan (N_ENTRIES=4)
- Reset with req=4'b1111 → gnt_valid=0, count=0, empty=1. Release, alloc 2,0,3 on successive cycles → count=3, valid=4'b1101.
- Order 2,0,3, req=4'b1111, issue_ready=1 → gnt_idx=2, then 0 on the next cycle, then 3, then gnt_valid=0 and empty=1.
- Order 2,0,3, req=4'b1001 → gnt_idx=0, gnt_onehot=4'b0001. Entry 2 is skipped because it is not ready.
- Order 2,0,3, alloc 1 and issue 2 in the same cycle → count stays 3. The next grants with req=1111 are 0,3,1.
- Reuse: issue 2, re-alloc 2 after 0,3 → 2 is the youngest, grant order 0,3,2. Alloc when full is ignored and count stays 4.
- flush together with alloc_en (idx 1) → valid=0 next cycle. Asynchronous rst_aL pulse mid-burst → outputs reach reset values without a clock edge.
